ibex_register_file_remap: RTL and testbench
===========================================

// Module: ibex_register_file_remap
//
// PURPOSE
//  Flip-flop register file with logical-to-physical remapping and secure erase.
//  - Every write lands in a fresh zeroed spare physical register; the previous one is zeroed and recycled.
//  - A mask-driven scrub engine zeroes selected logical registers, one per cycle.
//  Sits in the ibex ID stage in place of the plain FF register file.
//  Generalises single-idle remapping to NumSpare rotating spares and NumRead read ports.
//
// PARAMETERS
//  RV32E      0   1: 16 logical regs (NUM_WORDS=16), else 32
//  DataWidth  32  register width in bits
//  NumSpare   2   spare physical regs in free list, >=1; NUM_PHYS = NUM_WORDS-1+NumSpare
//  NumRead    2   combinational read ports, >=1
//
// PORTS
//  clk_i         in   1                 clock
//  rst_ni        in   1                 async reset, active low
//  test_en_i     in   1                 test enable, no functional effect
//  raddr_i       in   NumRead*5         read addresses, port k at [5k+4:5k]
//  rdata_o       out  NumRead*DataWidth read data, port k at [DataWidth*k +: DataWidth]
//  waddr_a_i     in   5                 write address
//  wdata_a_i     in   DataWidth         write data
//  we_a_i        in   1                 write enable
//  erase_req_i   in   1                 erase request, level
//  erase_mask_i  in   NUM_WORDS         logical regs to erase, bit 0 ignored
//  erase_busy_o  out  1                 erase in progress
//  erase_ack_o   out  1                 one-cycle pulse, erase complete
//
// BEHAVIOUR
//  Reset, asynchronous:
//   - map[i]=i; free list slot j = NUM_WORDS+j; free pointer 0.
//   - All physical regs 0; FSM IDLE; pending mask 0; erase_busy_o=0, erase_ack_o=0.
//  Addressing:
//   - RV32E=1 uses address bits [3:0] only.
//   - Logical 0 maps to physical 0, which is hard-wired 0.
//  Read: rdata_o[k] = phys[map[raddr_k]], combinational, zero latency, pre-edge state.
//  Write, we_a_i=1 and waddr!=0:
//   - p_new = free[ptr], p_old = map[waddr].
//   - At the edge: phys[p_new] <= wdata; map[waddr] <= p_new; phys[p_old] <= 0; free[ptr] <= p_old.
//   - ptr <= (ptr+1) mod NumSpare. Free-list occupancy is constant at NumSpare.
//   - Write to reg 0, or we_a_i=0: no state change.
//  Erase FSM, states IDLE / SCRUB / DONE:
//   - IDLE: erase_req_i=1 captures erase_mask_i into pending.
//     -> SCRUB if any bit[NUM_WORDS-1:1] is set, else -> DONE.
//   - SCRUB: let r = lowest set pending bit.
//     At the edge, phys[map[r]] <= 0 and pending[r] <= 0.
//     -> DONE when pending becomes 0.
//   - DONE: erase_ack_o=1 for this single cycle, then -> IDLE.
//   - erase_busy_o = (state != IDLE).
//   - Requests while busy are ignored.
//   - req still high in IDLE after DONE starts a new erase.
//  Latency: accept at cycle t, k masked regs -> erase_ack_o high in cycle t+1+k.
//  Concurrent write and erase:
//   - A write to r clears pending[r], so new data survives; old data is zeroed by release.
//   - If a write and the scrub hit the same r in one cycle, the write wins: new value kept, old physical zeroed.
//   - Writes and reads are never stalled by the FSM.
//  Reset mid-erase: FSM returns to IDLE, no ack, all state reset.
//  Invariant: map[1..] and free[] always form a permutation of physical 1..NUM_PHYS.
//
// TESTING
//  - Reset, read all regs on every port -> 0. Write x5=0xDEADBEEF.
//    -> map[5]=32, physical 5 zeroed, read x5=0xDEADBEEF next cycle.
//  - Write x1 repeatedly, 2*NumSpare+1 times, with values 1,2,3,...
//    -> read returns last value; all freed physicals are 0; permutation invariant holds.
//  - Erase mask 0x0000_0016 (x1,x2,x4) at cycle t.
//    -> busy t+1..t+4; ack in t+4; x1, x2, x4 read 0; others unchanged.
//  - Erase mask 0x1 or 0x0 -> ack in t+1, no register changes.
//  - Erase x3, x7 while writing x7=0x55 in the first SCRUB cycle -> x3=0, x7=0x55, ack at t+2.
//  - Assert rst_ni low during SCRUB -> ack never pulses, busy=0, all reads 0.

Source files
------------

// File: rtl/ibex_register_file_remap.sv
// Flip-flop register file with logical-to-physical remapping: every write lands in a zeroed
// spare physical register and the displaced one is zeroed and recycled; a mask-driven engine scrubs registers.
module ibex_register_file_remap #(
    parameter int unsigned RV32E     = 0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumSpare  = 2,
    parameter int unsigned NumRead   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           test_en_i,
    input  logic [NumRead*5-1:0]           raddr_i,
    output logic [NumRead*DataWidth-1:0]   rdata_o,
    input  logic [4:0]                     waddr_a_i,
    input  logic [DataWidth-1:0]           wdata_a_i,
    input  logic                           we_a_i,
    input  logic                           erase_req_i,
    input  logic [(RV32E != 0 ? 16 : 32)-1:0] erase_mask_i,
    output logic                           erase_busy_o,
    output logic                           erase_ack_o
);

    localparam int unsigned NUM_WORDS = (RV32E != 0) ? 16 : 32;
    localparam int unsigned AW        = (RV32E != 0) ? 4 : 5;
    localparam int unsigned NUM_PHYS  = NUM_WORDS - 1 + NumSpare;
    localparam int unsigned PW        = $clog2(NUM_PHYS + 1);
    localparam int unsigned PTRW      = (NumSpare > 1) ? $clog2(NumSpare) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCRUB,
        DONE
    } erase_state_e;

    logic [DataWidth-1:0] phys_q [NUM_PHYS+1];
    logic [PW-1:0]        map_q  [NUM_WORDS];
    logic [PW-1:0]        free_q [NumSpare];
    logic [PTRW-1:0]      ptr_q;

    erase_state_e         state_q, state_d;
    logic [NUM_WORDS-1:0] pending_q, pending_d;

    logic [AW-1:0] waddr;
    logic          write_en;
    logic [PW-1:0] p_new, p_old;
    logic [AW-1:0] scrub_idx;
    logic          scrub_do;
    logic [PW-1:0] scrub_phys;
    logic          unused_bits;

    assign unused_bits = ^{test_en_i, raddr_i, waddr_a_i};

    assign waddr    = waddr_a_i[AW-1:0];
    assign write_en = we_a_i && (waddr != '0);
    assign p_new    = free_q[ptr_q];
    assign p_old    = map_q[waddr];

    // Lowest set pending bit; bit 0 is never set in pending.
    always_comb begin
        scrub_idx = '0;
        for (int unsigned i = NUM_WORDS - 1; i >= 1; i--) begin
            if (pending_q[i]) scrub_idx = AW'(i);
        end
    end

    assign scrub_do   = (state_q == SCRUB) && (pending_q != '0);
    assign scrub_phys = map_q[scrub_idx];

    always_comb begin
        rdata_o = '0;
        for (int unsigned k = 0; k < NumRead; k++) begin
            rdata_o[DataWidth*k +: DataWidth] = phys_q[map_q[raddr_i[5*k +: AW]]];
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            IDLE: begin
                if (erase_req_i) begin
                    pending_d = {erase_mask_i[NUM_WORDS-1:1], 1'b0};
                    state_d   = (|erase_mask_i[NUM_WORDS-1:1]) ? SCRUB : DONE;
                end
            end
            SCRUB: begin
                if (scrub_do) pending_d[scrub_idx] = 1'b0;
                // A write refreshes its register, so it no longer needs scrubbing.
                if (write_en) pending_d[waddr] = 1'b0;
                if (pending_d == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign erase_busy_o = (state_q != IDLE);
    assign erase_ack_o  = (state_q == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Write assignments come last so a same-cycle write beats the scrub of the same register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_PHYS + 1; i++) phys_q[i] <= '0;
            for (int unsigned i = 0; i < NUM_WORDS; i++) map_q[i] <= PW'(i);
            for (int unsigned j = 0; j < NumSpare; j++) free_q[j] <= PW'(NUM_WORDS + j);
            ptr_q <= '0;
        end else begin
            if (scrub_do) phys_q[scrub_phys] <= '0;
            if (write_en) begin
                phys_q[p_old]  <= '0;
                phys_q[p_new]  <= wdata_a_i;
                map_q[waddr]   <= p_new;
                free_q[ptr_q]  <= p_old;
                ptr_q          <= (ptr_q == PTRW'(NumSpare - 1)) ? '0 : ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_register_file_remap.sv
// Directed self-checking bench for ibex_register_file_remap with default parameters
// (32 logical regs, 2 spares, 2 read ports).
module tb_ibex_register_file_remap;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        test_en = 1'b0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        erase_req = 1'b0;
    logic [31:0] erase_mask = '0;
    logic        erase_busy;
    logic        erase_ack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ibex_register_file_remap #(
        .RV32E    (0),
        .DataWidth(32),
        .NumSpare (2),
        .NumRead  (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_en_i   (test_en),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .waddr_a_i   (waddr),
        .wdata_a_i   (wdata),
        .we_a_i      (we),
        .erase_req_i (erase_req),
        .erase_mask_i(erase_mask),
        .erase_busy_o(erase_busy),
        .erase_ack_o (erase_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads a logical register on both ports and checks each.
    task automatic rchk(input string tag, input int addr, input logic [31:0] exp);
        raddr = {5'(addr), 5'(addr)};
        #1;
        check({tag, ".p0"}, {32'h0, rdata[31:0]}, {32'h0, exp});
        check({tag, ".p1"}, {32'h0, rdata[63:32]}, {32'h0, exp});
    endtask

    task automatic wr(input int addr, input logic [31:0] d);
        we = 1'b1;
        waddr = 5'(addr);
        wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Launch an erase and check busy/ack for the following n cycles.
    task automatic erase_seq(input string tag, input logic [31:0] mask, input int ack_cycle);
        erase_mask = mask;
        erase_req = 1'b1;
        for (int c = 1; c <= ack_cycle + 1; c++) begin
            tick();
            if (c == 1) erase_req = 1'b0;
            check($sformatf("%s.busy%0d", tag, c), {63'h0, erase_busy}, {63'h0, c <= ack_cycle});
            check($sformatf("%s.ack%0d", tag, c), {63'h0, erase_ack}, {63'h0, c == ack_cycle});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [33:0] seen;
        bit          dup;

        #12;
        check("rst.busy", {63'h0, erase_busy}, 64'h0);
        check("rst.ack", {63'h0, erase_ack}, 64'h0);
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            check($sformatf("rst.rd%0d", i), {32'h0, rdata[31:0]}, 64'h0);
            check($sformatf("rst.rd%0d", 31 - i), {32'h0, rdata[63:32]}, 64'h0);
        end
        check("rst.free0", {58'h0, dut.free_q[0]}, 64'd32);
        check("rst.free1", {58'h0, dut.free_q[1]}, 64'd33);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // First write goes to spare 32, physical 5 is recycled.
        wr(5, 32'hDEADBEEF);
        check("w5.map", {58'h0, dut.map_q[5]}, 64'd32);
        check("w5.phys5", {32'h0, dut.phys_q[5]}, 64'h0);
        check("w5.free0", {58'h0, dut.free_q[0]}, 64'd5);
        rchk("w5.rd", 5, 32'hDEADBEEF);

        // x1 written 5 times: map[1] ends at 5, free list {1,33}.
        for (int v = 1; v <= 5; v++) wr(1, 32'(v));
        rchk("w1.rd", 1, 32'd5);
        check("w1.map", {58'h0, dut.map_q[1]}, 64'd5);
        check("w1.free0", {58'h0, dut.free_q[0]}, 64'd1);
        check("w1.free1", {58'h0, dut.free_q[1]}, 64'd33);
        check("w1.phys1", {32'h0, dut.phys_q[1]}, 64'h0);
        check("w1.phys33", {32'h0, dut.phys_q[33]}, 64'h0);
        rchk("w1.x5", 5, 32'hDEADBEEF);
        seen = '0;
        dup = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (seen[dut.map_q[i]]) dup = 1'b1;
            seen[dut.map_q[i]] = 1'b1;
        end
        for (int j = 0; j < 2; j++) begin
            if (seen[dut.free_q[j]]) dup = 1'b1;
            seen[dut.free_q[j]] = 1'b1;
        end
        check("perm.set", {30'h0, seen}, {30'h0, 34'h3_FFFF_FFFE});
        check("perm.dup", {63'h0, dup}, 64'h0);

        // Writes to x0 and with we=0 change nothing.
        wr(0, 32'h1234);
        rchk("x0.rd", 0, 32'h0);
        we = 1'b0;
        waddr = 5'd2;
        wdata = 32'hBAD;
        tick();
        rchk("nowe.rd", 2, 32'h0);

        wr(2, 32'h22);
        wr(3, 32'h33);
        wr(4, 32'h44);
        wr(7, 32'h77);

        erase_seq("e16", 32'h16, 4);
        rchk("e16.x1", 1, 32'h0);
        rchk("e16.x2", 2, 32'h0);
        rchk("e16.x4", 4, 32'h0);
        rchk("e16.x3", 3, 32'h33);
        rchk("e16.x5", 5, 32'hDEADBEEF);
        rchk("e16.x7", 7, 32'h77);

        erase_seq("e1", 32'h1, 1);
        erase_seq("e0", 32'h0, 1);
        rchk("e0.x3", 3, 32'h33);
        rchk("e0.x7", 7, 32'h77);

        // Erase x3,x7 while x7 is rewritten in the first scrub cycle.
        erase_mask = 32'h88;
        erase_req = 1'b1;
        tick();
        erase_req = 1'b0;
        check("e88.busy1", {63'h0, erase_busy}, 64'h1);
        check("e88.ack1", {63'h0, erase_ack}, 64'h0);
        wr(7, 32'h55);
        check("e88.ack2", {63'h0, erase_ack}, 64'h1);
        tick();
        check("e88.busy3", {63'h0, erase_busy}, 64'h0);
        rchk("e88.x3", 3, 32'h0);
        rchk("e88.x7", 7, 32'h55);

        // Same register hit by scrub and write in one cycle: write wins.
        wr(2, 32'h11);
        erase_mask = 32'h4;
        erase_req = 1'b1;
        tick();
        erase_req = 1'b0;
        wr(2, 32'h99);
        check("col.ack", {63'h0, erase_ack}, 64'h1);
        rchk("col.x2", 2, 32'h99);
        rchk("col.x7", 7, 32'h55);

        // Reset during scrub.
        wr(4, 32'hCD);
        erase_mask = 32'h14;
        erase_req = 1'b1;
        tick();
        erase_req = 1'b0;
        check("rm.busy_pre", {63'h0, erase_busy}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm.busy", {63'h0, erase_busy}, 64'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("rm.ack%0d", c), {63'h0, erase_ack}, 64'h0);
        end
        rchk("rm.x2", 2, 32'h0);
        rchk("rm.x4", 4, 32'h0);
        rchk("rm.x5", 5, 32'h0);
        rchk("rm.x7", 7, 32'h0);
        check("rm.map5", {58'h0, dut.map_q[5]}, 64'd5);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rm.post_ack%0d", c), {63'h0, erase_ack}, 64'h0);
            check($sformatf("rm.post_busy%0d", c), {63'h0, erase_busy}, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
